// File: rtl/uart_tx_sequencer_pkg.sv
// Shared types and helpers for the UART transmit sequencer.
// Holds the FSM state encoding, the byte width and the counter width helper.
package uart_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } seq_state_t;

    // Width of the shared down-counter: wide enough for the larger of the
    // gap length and the ACK timeout, never narrower than one bit.
    function automatic int cnt_width(input int gap_cycles, input int ack_timeout);
        int max_v;
        if (gap_cycles > ack_timeout) begin
            max_v = gap_cycles;
        end else begin
            max_v = ack_timeout;
        end
        if (max_v > 0) begin
            return $clog2(max_v + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Byte-write interface between the sequencer and the UART transmitter.
// master = sequencer side (drives data/strobe/enable), slave = UART side.
interface uart_tx_sequencer_if;
    import uart_seq_pkg::*;

    logic [BYTE_W-1:0] Tx_DATA;
    logic              Tx_WR;
    logic              Tx_EN;
    logic              Tx_BUSY;

    modport master (
        output Tx_DATA,
        output Tx_WR,
        output Tx_EN,
        input  Tx_BUSY
    );

    modport slave (
        input  Tx_DATA,
        input  Tx_WR,
        input  Tx_EN,
        output Tx_BUSY
    );

endinterface

// File: rtl/uart_tx_sequencer_cycle_counter.sv
// Loadable down-counter with a zero flag. The sequencer shares one instance
// between the ACK timeout (WAIT_HI) and the inter-byte gap (GAP), which are
// never active at the same time. Load has priority over decrement; the
// counter saturates at zero.
module seq_cycle_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load, saturating decrement, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: snapshots a MSG_LEN-byte message on start and
// feeds it byte by byte to the UART, paced by Tx_BUSY, with an idle gap
// after each byte. A missing busy acknowledge aborts with a sticky error.
// Optional feature: define UART_TX_SEQ_REPEAT_EN to add the repeat_i input,
// which resends the captured message instead of finishing while it is high.
// All outputs come straight from registers.
module uart_tx_sequencer
    import uart_seq_pkg::*;
#(
    parameter int MSG_LEN     = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BYTE_W*MSG_LEN-1:0] msg_data,
`ifdef UART_TX_SEQ_REPEAT_EN
    input  logic                      repeat_i,
`endif
    output logic                      seq_busy,
    output logic                      seq_done,
    output logic                      seq_error,
    uart_tx_sequencer_if.master       tx_if
);

    localparam int CNT_W = cnt_width(GAP_CYCLES, ACK_TIMEOUT);
    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
    // The timeout counter expires on its zero value, so it is loaded one
    // short of the limit to flag the error on the ACK_TIMEOUT-th clock.
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);

    seq_state_t                state_q;
    seq_state_t                state_d;
    logic [IDX_W-1:0]          idx_q;
    logic [IDX_W-1:0]          idx_d;
    logic [BYTE_W*MSG_LEN-1:0] msg_q;
    logic [BYTE_W*MSG_LEN-1:0] msg_d;
    logic [BYTE_W-1:0]         tx_data_q;
    logic [BYTE_W-1:0]         tx_data_d;
    logic                      tx_wr_q;
    logic                      tx_wr_d;
    logic                      busy_q;
    logic                      busy_d;
    logic                      done_q;
    logic                      done_d;
    logic                      error_q;
    logic                      error_d;

    logic                      cnt_load_s;
    logic [CNT_W-1:0]          cnt_val_s;
    logic                      cnt_dec_s;
    logic                      cnt_zero_s;

    seq_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_val_s),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Next-state, next-output and counter control for the message FSM
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        msg_d      = msg_q;
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        cnt_load_s = 1'b0;
        cnt_val_s  = {CNT_W{1'b0}};
        cnt_dec_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    msg_d   = msg_data;
                    idx_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    state_d = ISSUE;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            ISSUE: begin
                if (!tx_if.Tx_BUSY) begin
                    tx_wr_d    = 1'b1;
                    tx_data_d  = msg_q[int'(idx_q) * BYTE_W +: BYTE_W];
                    cnt_load_s = 1'b1;
                    cnt_val_s  = ACK_LOAD;
                    state_d    = WAIT_HI;
                end else begin
                    state_d = ISSUE;
                end
            end

            WAIT_HI: begin
                if (tx_if.Tx_BUSY) begin
                    state_d = WAIT_LO;
                end else if (cnt_zero_s) begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = ERROR;
                end else begin
                    cnt_dec_s = 1'b1;
                    state_d   = WAIT_HI;
                end
            end

            WAIT_LO: begin
                if (!tx_if.Tx_BUSY) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = GAP_LOAD;
                    state_d    = GAP;
                end else begin
                    state_d = WAIT_LO;
                end
            end

            GAP: begin
                if (!cnt_zero_s) begin
                    cnt_dec_s = 1'b1;
                    state_d   = GAP;
                end else if (idx_q == LAST_IDX) begin
`ifdef UART_TX_SEQ_REPEAT_EN
                    if (repeat_i) begin
                        idx_d   = {IDX_W{1'b0}};
                        state_d = ISSUE;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
`else
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ISSUE;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            ERROR: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs; reset aborts any message in flight
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx_q     <= {IDX_W{1'b0}};
            msg_q     <= {(BYTE_W*MSG_LEN){1'b0}};
            tx_data_q <= {BYTE_W{1'b0}};
            tx_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            msg_q     <= msg_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign seq_busy      = busy_q;
    assign seq_done      = done_q;
    assign seq_error     = error_q;
    assign tx_if.Tx_DATA = tx_data_q;
    assign tx_if.Tx_WR   = tx_wr_q;
    assign tx_if.Tx_EN   = busy_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: expected bytes are queued when a
// message is issued, a monitor pops and compares on every Tx_WR strobe, and
// a small UART model answers each strobe with a Tx_BUSY pulse.
module tb_uart_tx_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] msg_data = 32'h0;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_error;
`ifdef UART_TX_SEQ_REPEAT_EN
    logic        repeat_i = 1'b0;
`endif

    logic        model_busy = 1'b0;
    logic        hold_busy = 1'b0;
    logic        model_en = 1'b1;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          strobe_cnt = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];

    int          ack_dly [3] = '{1, 3, 2};
    int          busy_len [6] = '{2, 10, 5, 7, 3, 9};

    uart_tx_sequencer_if tx_if ();

    assign tx_if.Tx_BUSY = model_busy | hold_busy;

    uart_tx_sequencer #(
        .MSG_LEN     (4),
        .GAP_CYCLES  (16),
        .ACK_TIMEOUT (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .msg_data  (msg_data),
`ifdef UART_TX_SEQ_REPEAT_EN
        .repeat_i  (repeat_i),
`endif
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .seq_error (seq_error),
        .tx_if     (tx_if)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_msg(input logic [31:0] msg);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(msg[i*8 +: 8]);
        end
    endtask

    // Returns at the negedge following the edge that accepted start.
    task automatic pulse_start(input logic [31:0] msg);
        @(negedge clock);
        msg_data = msg;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("done_wait", done_cnt, target);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n;
        n = 0;
        while (strobe_cnt < target && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("strobe_wait", strobe_cnt, target);
    endtask

    // UART model: acknowledges each strobe with a busy pulse of varying shape
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clock);
            if (tx_if.Tx_WR === 1'b1 && model_en) begin
                repeat (ack_dly[k % 3]) @(negedge clock);
                model_busy = 1'b1;
                repeat (busy_len[k % 6]) @(negedge clock);
                model_busy = 1'b0;
                k++;
            end
        end
    end

    // Monitor: scoreboard on strobes, done pulses counted
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clock);
            if (tx_if.Tx_WR === 1'b1) begin
                strobe_cnt++;
                check("strobe_en", tx_if.Tx_EN, 1'b1);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_strobe: got data %0h, expected no strobe", tx_if.Tx_DATA);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("strobe_data", tx_if.Tx_DATA, exp_b);
                end
            end
            if (seq_done === 1'b1) begin
                done_cnt++;
                check("done_after_last_byte", exp_q.size(), 0);
            end
        end
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_s;
        int base_d;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", seq_busy, 1'b0);
        check("rst_done", seq_done, 1'b0);
        check("rst_error", seq_error, 1'b0);
        check("rst_wr", tx_if.Tx_WR, 1'b0);
        check("rst_en", tx_if.Tx_EN, 1'b0);
        check("rst_data", tx_if.Tx_DATA, 8'h00);
        reset = 1'b1;
        @(negedge clock);

        // 1: basic message with latency check
        base_s = strobe_cnt;
        base_d = done_cnt;
        push_msg(32'h44332211);
        pulse_start(32'h44332211);
        check("t1_busy_after_start", seq_busy, 1'b1);
        check("t1_en_after_start", tx_if.Tx_EN, 1'b1);
        check("t1_wr_not_yet", tx_if.Tx_WR, 1'b0);
        @(negedge clock);
        check("t1_wr_latency", tx_if.Tx_WR, 1'b1);
        check("t1_data_byte0", tx_if.Tx_DATA, 8'h11);
        wait_done(base_d + 1, 800);
        @(negedge clock);
        check("t1_strobes", strobe_cnt - base_s, 4);
        check("t1_busy_low", seq_busy, 1'b0);
        check("t1_en_low", tx_if.Tx_EN, 1'b0);
        check("t1_no_error", seq_error, 1'b0);
        check("t1_data_hold", tx_if.Tx_DATA, 8'h44);

        // 2: hold-off while the UART is busy
        base_s = strobe_cnt;
        base_d = done_cnt;
        hold_busy = 1'b1;
        push_msg(32'h5A6B7C8D);
        pulse_start(32'h5A6B7C8D);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t2_holdoff_wr", tx_if.Tx_WR, 1'b0);
        end
        hold_busy = 1'b0;
        @(negedge clock);
        check("t2_wr_after_release", tx_if.Tx_WR, 1'b1);
        wait_done(base_d + 1, 800);
        check("t2_strobes", strobe_cnt - base_s, 4);

        // 3: ACK timeout
        repeat (5) @(negedge clock);
        base_s = strobe_cnt;
        model_en = 1'b0;
        exp_q.push_back(8'hE1);
        pulse_start(32'hE4E3E2E1);
        @(negedge clock);
        check("t3_strobe", tx_if.Tx_WR, 1'b1);
        repeat (7) @(negedge clock);
        check("t3_error_not_early", seq_error, 1'b0);
        @(negedge clock);
        check("t3_error_set", seq_error, 1'b1);
        check("t3_busy_low", seq_busy, 1'b0);
        check("t3_en_low", tx_if.Tx_EN, 1'b0);
        repeat (20) @(negedge clock);
        check("t3_no_more_strobes", strobe_cnt - base_s, 1);
        check("t3_error_sticky", seq_error, 1'b1);
        model_en = 1'b1;

        // 4: reset during the second byte, then a fresh message
        base_s = strobe_cnt;
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0B);
        pulse_start(32'h0D0C0B0A);
        check("t4_error_cleared", seq_error, 1'b0);
        wait_strobes(base_s + 2, 300);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t4_rst_busy", seq_busy, 1'b0);
        check("t4_rst_done", seq_done, 1'b0);
        check("t4_rst_error", seq_error, 1'b0);
        check("t4_rst_wr", tx_if.Tx_WR, 1'b0);
        check("t4_rst_en", tx_if.Tx_EN, 1'b0);
        check("t4_rst_data", tx_if.Tx_DATA, 8'h00);
        check("t4_queue_drained", exp_q.size(), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        check("t4_no_strobe_after_reset", strobe_cnt - base_s, 2);
        base_s = strobe_cnt;
        base_d = done_cnt;
        push_msg(32'h0D0C0B0A);
        pulse_start(32'h0D0C0B0A);
        wait_done(base_d + 1, 800);
        check("t4_restart_strobes", strobe_cnt - base_s, 4);

        // 5: start during a transfer is ignored
        repeat (5) @(negedge clock);
        base_s = strobe_cnt;
        base_d = done_cnt;
        push_msg(32'h87654321);
        pulse_start(32'h87654321);
        wait_strobes(base_s + 2, 300);
        pulse_start(32'hFFFFFFFF);
        wait_done(base_d + 1, 800);
        repeat (60) @(negedge clock);
        check("t5_strobes", strobe_cnt - base_s, 4);
        check("t5_done_count", done_cnt - base_d, 1);
        check("t5_idle_busy", seq_busy, 1'b0);

`ifdef UART_TX_SEQ_REPEAT_EN
        // 6: repeat for two extra passes
        base_s = strobe_cnt;
        base_d = done_cnt;
        repeat_i = 1'b1;
        push_msg(32'h44332211);
        push_msg(32'h44332211);
        push_msg(32'h44332211);
        pulse_start(32'h44332211);
        wait_strobes(base_s + 9, 1500);
        check("t6_no_early_done", done_cnt - base_d, 0);
        check("t6_busy_held", seq_busy, 1'b1);
        repeat_i = 1'b0;
        wait_done(base_d + 1, 800);
        repeat (40) @(negedge clock);
        check("t6_strobes", strobe_cnt - base_s, 12);
        check("t6_done_count", done_cnt - base_d, 1);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
